// File: rtl/idex_hazard_stage.sv
// rtl/idex_hazard_stage.sv - ID/EX pipeline register with load-use and branch-hazard stall control
module idex_hazard_stage #(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 4,
  parameter int ALUOP_W  = 4,
  parameter int LB_STALL = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_uses_rt,
  input  logic               id_regdst,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic               id_is_branch,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic [DATA_W-1:0]  id_rd1,
  input  logic [DATA_W-1:0]  id_rd2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               exmem_memread,
  input  logic [REG_AW-1:0]  exmem_rd,
  input  logic               mem_busy,
  input  logic               flush,
  output logic               hazard_stall,
  output logic               idex_valid,
  output logic [REG_AW-1:0]  idex_rs,
  output logic [REG_AW-1:0]  idex_rt,
  output logic [REG_AW-1:0]  idex_rt_rd,
  output logic               idex_regwrite,
  output logic               idex_memread,
  output logic               idex_memwrite,
  output logic [ALUOP_W-1:0] idex_aluop,
  output logic [DATA_W-1:0]  idex_rd1,
  output logic [DATA_W-1:0]  idex_rd2,
  output logic [DATA_W-1:0]  idex_imm
);

  // A branch behind a load in EX waits LB_STALL cycles; the counter holds the extra ones.
  localparam logic [1:0] LB_RELOAD = 2'(LB_STALL - 1);

  logic [1:0] stall_cnt;
  logic       cnt_active;
  logic       ex_src_hit;
  logic       mem_src_hit;
  logic       lu;
  logic       lb_ex;
  logic       lb_mem;
  logic       detect;
  logic       stalling;

  // Hazard detection; register 0 never counts as a real dependency.
  always_comb begin
    cnt_active   = (stall_cnt != 2'd0);
    ex_src_hit   = (idex_rt_rd == id_rs) | (id_uses_rt & (idex_rt_rd == id_rt));
    mem_src_hit  = (exmem_rd == id_rs) | (id_uses_rt & (exmem_rd == id_rt));
    lu           = idex_valid & idex_memread & (idex_rt_rd != '0) & ex_src_hit;
    lb_ex        = lu & id_is_branch;
    lb_mem       = id_is_branch & exmem_memread & (exmem_rd != '0) & mem_src_hit;
    detect       = id_valid & ~cnt_active & (lu | lb_mem);
    stalling     = detect | cnt_active;
    hazard_stall = stalling | mem_busy;
  end

  // Remaining stall cycles; detection is masked while nonzero so a load is counted once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 2'd0;
    end else if (flush) begin
      stall_cnt <= 2'd0;
    end else if (mem_busy) begin
      stall_cnt <= stall_cnt;
    end else if (detect) begin
      stall_cnt <= lb_ex ? LB_RELOAD : 2'd0;
    end else if (cnt_active) begin
      stall_cnt <= stall_cnt - 2'd1;
    end
  end

  // Pipeline register: flush and stalls insert a bubble, mem_busy freezes the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid    <= 1'b0;
      idex_rs       <= '0;
      idex_rt       <= '0;
      idex_rt_rd    <= '0;
      idex_regwrite <= 1'b0;
      idex_memread  <= 1'b0;
      idex_memwrite <= 1'b0;
      idex_aluop    <= '0;
      idex_rd1      <= '0;
      idex_rd2      <= '0;
      idex_imm      <= '0;
    end else if (flush || (!mem_busy && stalling)) begin
      idex_valid    <= 1'b0;
      idex_rs       <= '0;
      idex_rt       <= '0;
      idex_rt_rd    <= '0;
      idex_regwrite <= 1'b0;
      idex_memread  <= 1'b0;
      idex_memwrite <= 1'b0;
      idex_aluop    <= '0;
      idex_rd1      <= '0;
      idex_rd2      <= '0;
      idex_imm      <= '0;
    end else if (!mem_busy) begin
      idex_valid    <= id_valid;
      idex_rs       <= id_rs;
      idex_rt       <= id_rt;
      idex_rt_rd    <= id_regdst ? id_rd : id_rt;
      idex_regwrite <= id_valid & id_regwrite;
      idex_memread  <= id_valid & id_memread;
      idex_memwrite <= id_valid & id_memwrite;
      idex_aluop    <= id_aluop;
      idex_rd1      <= id_rd1;
      idex_rd2      <= id_rd2;
      idex_imm      <= id_imm;
    end
  end

endmodule

// File: tb/tb_idex_hazard_stage.sv
// tb/tb_idex_hazard_stage.sv - scoreboard bench for idex_hazard_stage
module tb_idex_hazard_stage;

  typedef struct {
    logic v; logic [3:0] rs, rt, rd;
    logic uses_rt, regdst, rw, mr, mw, br;
    logic [3:0] aluop; logic [15:0] rd1, rd2, imm;
  } instr_t;

  typedef struct {
    logic v; logic [3:0] rs, rt, rt_rd;
    logic rw, mr, mw;
    logic [3:0] aluop; logic [15:0] rd1, rd2, imm;
  } exp_t;

  typedef struct { logic stall; exp_t st; } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 0, id_uses_rt = 0, id_regdst = 0, id_regwrite = 0;
  logic id_memread = 0, id_memwrite = 0, id_is_branch = 0;
  logic [3:0] id_rs = 0, id_rt = 0, id_rd = 0, id_aluop = 0;
  logic [15:0] id_rd1 = 0, id_rd2 = 0, id_imm = 0;
  logic exmem_memread = 0, mem_busy = 0, flush = 0;
  logic [3:0] exmem_rd = 0;
  logic hazard_stall, idex_valid, idex_regwrite, idex_memread, idex_memwrite;
  logic [3:0] idex_rs, idex_rt, idex_rt_rd, idex_aluop;
  logic [15:0] idex_rd1, idex_rd2, idex_imm;

  int n_cmp = 0;
  int n_bad = 0;
  sb_t sb_q[$];

  idex_hazard_stage #(.DATA_W(16), .REG_AW(4), .ALUOP_W(4), .LB_STALL(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_regdst(id_regdst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_is_branch(id_is_branch), .id_aluop(id_aluop), .id_rd1(id_rd1),
    .id_rd2(id_rd2), .id_imm(id_imm), .exmem_memread(exmem_memread),
    .exmem_rd(exmem_rd), .mem_busy(mem_busy), .flush(flush),
    .hazard_stall(hazard_stall), .idex_valid(idex_valid), .idex_rs(idex_rs),
    .idex_rt(idex_rt), .idex_rt_rd(idex_rt_rd), .idex_regwrite(idex_regwrite),
    .idex_memread(idex_memread), .idex_memwrite(idex_memwrite),
    .idex_aluop(idex_aluop), .idex_rd1(idex_rd1), .idex_rd2(idex_rd2),
    .idex_imm(idex_imm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic v, input logic [3:0] rs, rt, rd,
                                input logic ur, dst, rw, mr, mw, br, input logic [3:0] op,
                                input logic [15:0] d1, d2, im);
    instr_t i;
    i.v = v; i.rs = rs; i.rt = rt; i.rd = rd; i.uses_rt = ur; i.regdst = dst;
    i.rw = rw; i.mr = mr; i.mw = mw; i.br = br; i.aluop = op;
    i.rd1 = d1; i.rd2 = d2; i.imm = im;
    return i;
  endfunction

  function automatic instr_t mk_add(input logic [3:0] rs, rt, rd, input logic [15:0] d1);
    return mk(1, rs, rt, rd, 1, 1, 1, 0, 0, 0, 4'h2, d1, 16'h00a5, 16'h0000);
  endfunction
  function automatic instr_t mk_lw(input logic [3:0] base, dst);
    return mk(1, base, dst, 4'h0, 0, 0, 1, 1, 0, 0, 4'h2, 16'h0100, 16'h0000, 16'h0008);
  endfunction
  function automatic instr_t mk_addi(input logic [3:0] rs, dst, input logic [15:0] im);
    return mk(1, rs, dst, 4'h0, 0, 0, 1, 0, 0, 0, 4'h2, 16'h0200, 16'h0000, im);
  endfunction
  function automatic instr_t mk_beq(input logic [3:0] rs, rt);
    return mk(1, rs, rt, 4'h0, 1, 0, 0, 0, 0, 1, 4'h6, 16'h0300, 16'h0301, 16'hfffc);
  endfunction

  // Expected registered image of an instruction that is accepted.
  function automatic exp_t ld(input instr_t i);
    exp_t e;
    e.v = i.v; e.rs = i.rs; e.rt = i.rt; e.rt_rd = i.regdst ? i.rd : i.rt;
    e.rw = i.v & i.rw; e.mr = i.v & i.mr; e.mw = i.v & i.mw;
    e.aluop = i.aluop; e.rd1 = i.rd1; e.rd2 = i.rd2; e.imm = i.imm;
    return e;
  endfunction

  function automatic exp_t bub();
    exp_t e;
    e.v = 0; e.rs = 0; e.rt = 0; e.rt_rd = 0; e.rw = 0; e.mr = 0; e.mw = 0;
    e.aluop = 0; e.rd1 = 0; e.rd2 = 0; e.imm = 0;
    return e;
  endfunction

  task automatic drive(input instr_t i, input logic fl, bz, emr, input logic [3:0] erd);
    id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
    id_uses_rt = i.uses_rt; id_regdst = i.regdst; id_regwrite = i.rw;
    id_memread = i.mr; id_memwrite = i.mw; id_is_branch = i.br;
    id_aluop = i.aluop; id_rd1 = i.rd1; id_rd2 = i.rd2; id_imm = i.imm;
    flush = fl; mem_busy = bz; exmem_memread = emr; exmem_rd = erd;
  endtask

  // One cycle: apply inputs and queue the expected stall now and idex image after the edge.
  task automatic step(input instr_t i, input logic fl, bz, emr, input logic [3:0] erd,
                      input logic es, input exp_t ea);
    sb_t s;
    @(posedge clk);
    #1;
    drive(i, fl, bz, emr, erd);
    s.stall = es; s.st = ea;
    sb_q.push_back(s);
  endtask

  // Monitor: stall is checked mid-cycle, the registered image just after the next edge.
  initial begin
    sb_t s;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        s = sb_q.pop_front();
        chk("hazard_stall", 32'(hazard_stall), 32'(s.stall));
        @(posedge clk);
        #2;
        chk("idex_valid", 32'(idex_valid), 32'(s.st.v));
        chk("idex_rs", 32'(idex_rs), 32'(s.st.rs));
        chk("idex_rt", 32'(idex_rt), 32'(s.st.rt));
        chk("idex_rt_rd", 32'(idex_rt_rd), 32'(s.st.rt_rd));
        chk("idex_ctrl", {29'd0, idex_regwrite, idex_memread, idex_memwrite},
            {29'd0, s.st.rw, s.st.mr, s.st.mw});
        chk("idex_aluop", 32'(idex_aluop), 32'(s.st.aluop));
        chk("idex_rd1", 32'(idex_rd1), 32'(s.st.rd1));
        chk("idex_rd2_imm", {idex_rd2, idex_imm}, {s.st.rd2, s.st.imm});
      end
    end
  end

  initial begin
    instr_t n, a, l2, ai, l3, q, q45, a6, q60, l0, a0, q00, a8, ab, a456, nv, nv2;
    exp_t b;
    n = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    a = mk_add(4'd2, 4'd3, 4'd4, 16'h0a0a);
    l2 = mk_lw(4'd5, 4'd2);
    ai = mk_addi(4'd2, 4'd7, 16'h0001);
    l3 = mk_lw(4'd1, 4'd3);
    q = mk_beq(4'd2, 4'd3);
    q45 = mk_beq(4'd4, 4'd5);
    a6 = mk_add(4'd1, 4'd1, 4'd6, 16'h0006);
    q60 = mk_beq(4'd6, 4'd0);
    l0 = mk_lw(4'd1, 4'd0);
    a0 = mk_add(4'd0, 4'd0, 4'd5, 16'h0000);
    q00 = mk_beq(4'd0, 4'd0);
    a8 = mk_add(4'd8, 4'd9, 4'd10, 16'h0808);
    ab = mk_add(4'd1, 4'd2, 4'd3, 16'h1234);
    a456 = mk_add(4'd4, 4'd5, 4'd6, 16'h0456);
    nv = mk(0, 4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    nv2 = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 16'h0, 16'h0, 16'h0);
    b = bub();

    // Reset state
    #2;
    chk("rst_hazard_stall", 32'(hazard_stall), 32'd0);
    chk("rst_idex_valid", 32'(idex_valid), 32'd0);
    chk("rst_idex_rt_rd", 32'(idex_rt_rd), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Plain add, then load-use with one bubble
    step(a, 0, 0, 0, 4'd0, 0, ld(a));
    step(n, 0, 0, 0, 4'd0, 0, b);
    step(l2, 0, 0, 0, 4'd0, 0, ld(l2));
    step(ai, 0, 0, 0, 4'd0, 1, b);
    step(ai, 0, 0, 0, 4'd0, 0, ld(ai));
    step(n, 0, 0, 0, 4'd0, 0, b);

    // Branch behind load in EX: two bubbles
    step(l3, 0, 0, 0, 4'd0, 0, ld(l3));
    step(q, 0, 0, 0, 4'd0, 1, b);
    step(q, 0, 0, 1, 4'd3, 1, b);
    step(q, 0, 0, 0, 4'd0, 0, ld(q));

    // Branch behind load in MEM only: one bubble; branch on ALU result: none
    step(q45, 0, 0, 1, 4'd4, 1, b);
    step(q45, 0, 0, 0, 4'd0, 0, ld(q45));
    step(a6, 0, 0, 0, 4'd0, 0, ld(a6));
    step(q60, 0, 0, 0, 4'd0, 0, ld(q60));

    // r0 as load destination never stalls
    step(l0, 0, 0, 0, 4'd0, 0, ld(l0));
    step(a0, 0, 0, 0, 4'd0, 0, ld(a0));
    step(q00, 0, 0, 1, 4'd0, 0, ld(q00));

    // Flush aborts a two-cycle branch stall
    step(l3, 0, 0, 0, 4'd0, 0, ld(l3));
    step(q, 0, 0, 0, 4'd0, 1, b);
    step(q, 1, 0, 1, 4'd3, 1, b);
    step(a8, 0, 0, 0, 4'd0, 0, ld(a8));
    step(a, 1, 0, 0, 4'd0, 0, b);

    // mem_busy freezes the stage
    step(ab, 0, 0, 0, 4'd0, 0, ld(ab));
    for (int k = 0; k < 3; k++) step(a456, 0, 1, 0, 4'd0, 1, ld(ab));
    step(a456, 0, 0, 0, 4'd0, 0, ld(a456));

    // mem_busy freezes the stall counter mid-stall
    step(l3, 0, 0, 0, 4'd0, 0, ld(l3));
    step(q, 0, 0, 0, 4'd0, 1, b);
    step(q, 0, 1, 1, 4'd3, 1, b);
    step(q, 0, 0, 1, 4'd3, 1, b);
    step(q, 0, 0, 0, 4'd0, 0, ld(q));

    // Invalid ID never stalls and its controls are dropped
    step(l2, 0, 0, 0, 4'd0, 0, ld(l2));
    step(nv, 0, 0, 0, 4'd0, 0, ld(nv));
    step(nv2, 0, 0, 0, 4'd0, 0, b);

    // Reset mid-stall
    step(l3, 0, 0, 0, 4'd0, 0, ld(l3));
    step(q, 0, 0, 0, 4'd0, 1, b);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_hazard_stall", 32'(hazard_stall), 32'd0);
    chk("midrst_idex_valid", 32'(idex_valid), 32'd0);
    chk("midrst_idex_rs", 32'(idex_rs), 32'd0);
    chk("midrst_idex_rd1", 32'(idex_rd1), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step(q, 0, 0, 0, 4'd0, 0, ld(q));
    step(a, 0, 0, 0, 4'd0, 0, ld(a));
    step(n, 0, 0, 0, 4'd0, 0, b);

    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/idex_hazard_stage.md
Name: idex_hazard_stage

Overview:
- ID/EX pipeline register with integrated load-use and branch-hazard stall control for the 16-bit, 16-register pipelined CPU.
- Captures decoded ID fields and presents the registered `idex_*` fields that the forwarding unit and EX stage consume. This includes the `idex_rt_rd` destination select.
- Cases that forwarding cannot cover are handled by stalling PC/IF-ID and inserting bubbles.

Parameters:
- DATA_W, 16, operand/immediate width
- REG_AW, 4, register address width; register 0 is the hardwired zero register
- ALUOP_W, 4, ALU opcode width
- LB_STALL, 2, stall cycles for a branch in ID depending on a load in EX

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt, id_rd  in  REG_AW  decoded register addresses
- id_uses_rt  in  1  instruction reads rt as a source
- id_regdst  in  1  1: destination is rd; 0: destination is rt
- id_regwrite, id_memread, id_memwrite, id_is_branch  in  1  decoded controls
- id_aluop  in  ALUOP_W  ALU operation
- id_rd1, id_rd2, id_imm  in  DATA_W  register-file reads and sign-extended immediate
- exmem_memread  in  1  load currently in MEM
- exmem_rd  in  REG_AW  MEM-stage destination
- mem_busy  in  1  downstream hold; freezes this stage
- flush  in  1  squash the instruction entering ID/EX
- hazard_stall  out  1  hold PC and IF/ID this cycle (combinational)
- idex_valid  out  1  registered valid
- idex_rs, idex_rt, idex_rt_rd  out  REG_AW  registered sources; selected destination
- idex_regwrite, idex_memread, idex_memwrite  out  1  registered controls
- idex_aluop  out  ALUOP_W
- idex_rd1, idex_rd2, idex_imm  out  DATA_W

Behaviour:
- Reset (async, rst_n=0): all idex_* outputs are 0, stall_cnt=0, hazard_stall=0.
- Latency: 1 cycle from ID inputs to idex_* outputs.
- Destination select: idex_rt_rd = id_regdst ? id_rd : id_rt, registered.
- Hazard detection is combinational and is evaluated only when id_valid=1 and stall_cnt=0.
  - Load-use (lu): idex_valid & idex_memread & idex_rt_rd≠0 & (idex_rt_rd==id_rs | (id_uses_rt & idex_rt_rd==id_rt)).
  - Branch-after-load in EX (lb_ex): lu & id_is_branch. This needs LB_STALL cycles.
  - Branch-after-load in MEM (lb_mem): id_is_branch & exmem_memread & exmem_rd≠0 & exmem_rd matches id_rs, or matches id_rt when id_uses_rt=1. This needs 1 cycle.
  - A branch reading a non-load EX result does not stall; the forwarding path covers it.
- Stall counter, 2 bits:
  - Detect with stall_cnt=0: stall this cycle. Load stall_cnt with (needed−1): LB_STALL−1 for lb_ex, 0 for lu or lb_mem.
  - stall_cnt≠0: stall this cycle and decrement. Detection is ignored while nonzero, so there is no double-counting as the load advances.
- hazard_stall = detect | (stall_cnt≠0) | mem_busy.
- ID/EX update priority, evaluated per rising edge:
  1. flush: load a bubble and clear stall_cnt.
  2. mem_busy: hold all idex_* and stall_cnt unchanged.
  3. Stalling (detect or stall_cnt≠0): load a bubble.
  4. Otherwise: load ID fields, with idex_valid = id_valid.
- Bubble: all idex_* fields are 0, including valid and controls.
- Flush during a multi-cycle stall aborts the stall; the next cycle starts from stall_cnt=0.
- Register 0 as destination never triggers a stall.
- id_valid=0 never triggers a stall; its controls are forced to 0 when loaded.

Test Plan:
- Reset mid-stream, then id add r2,r3→r4 (regdst=1, regwrite=1) -> next cycle idex_valid=1, idex_rt_rd=4, idex_rs=2, idex_rt=3, hazard_stall=0.
- Load r2 in EX, then ID addi r2,r2,1 -> hazard_stall=1 for 1 cycle, one bubble (idex_valid=0), then the addi is loaded with idex_rs=2.
- Load r3 in EX, then ID beq r2,r3 -> hazard_stall=1 for exactly 2 cycles, 2 bubbles, then the beq proceeds.
- Load with destination r0 followed by a user of r0 -> no stall, hazard_stall=0.
- 2-cycle branch stall with flush asserted in the 2nd cycle -> bubble loaded, stall_cnt=0, new ID instruction accepted the following cycle.
- mem_busy=1 for 3 cycles while idex holds an instruction with rd1=0x1234 -> idex_rd1 stays 0x1234, hazard_stall=1, stall_cnt frozen; resumes cleanly when mem_busy drops.
